// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch controller: FSM states and the
// {inst, pc, fault} slot handed to ID.
package if_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DREQ,
    DWAIT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } fetch_slot_t;

endpackage

// File: rtl/if_skid_buf.sv
// Output register plus one-entry skid for fetch results; flush empties both
// and wins over any simultaneous write.
module if_skid_buf
  import if_pkg::*;
#(
  parameter logic [31:0] NOP_INST = if_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  fetch_slot_t in_slot,
  input  logic        consume,
  input  logic        flush,
  output logic        out_valid,
  output fetch_slot_t out_slot,
  output logic        skid_empty
);

  logic        skid_valid;
  fetch_slot_t skid_slot;
  logic        taken;

  assign taken      = out_valid && consume;
  assign skid_empty = !skid_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_slot   <= '{inst: NOP_INST, pc: 32'h0, fault: 1'b0};
      skid_valid <= 1'b0;
      skid_slot  <= '{inst: NOP_INST, pc: 32'h0, fault: 1'b0};
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (taken && skid_valid) begin
      // Refill from skid; an arriving result queues behind it in order.
      out_slot   <= skid_slot;
      skid_valid <= in_valid;
      if (in_valid) skid_slot <= in_slot;
    end else if (taken || !out_valid) begin
      out_valid <= in_valid;
      if (in_valid) out_slot <= in_slot;
    end else if (in_valid) begin
      skid_valid <= 1'b1;
      skid_slot  <= in_slot;
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: one outstanding instruction-bus read, redirect
// flushing, local misalignment faults, and PC-register enable generation.
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter int          ALIGN_CHECK = 1,
  parameter logic [31:0] NOP_INST    = if_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic        pc_en,
  input  logic        redirect,
  input  logic        id_stall,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_gnt,
  input  logic        ibus_rvalid,
  input  logic [31:0] ibus_rdata,
  input  logic        ibus_err,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        inst_fault
);

  fetch_state_t state;
  logic [31:0]  pend_pc;
  logic         misaligned;
  logic         skid_empty;
  logic         fault_wr;
  logic         rsp_wr;
  logic         in_valid;
  fetch_slot_t  in_slot;
  fetch_slot_t  out_slot;

  assign misaligned = (ALIGN_CHECK != 0) && (pc[1:0] != 2'b00);
  // Fault slots are gated on skid space just like bus issues, so the skid never overflows.
  assign fault_wr   = (state == IDLE) && !redirect && skid_empty && misaligned;
  assign rsp_wr     = (state == WAIT) && ibus_rvalid && !redirect;
  assign in_valid   = fault_wr || rsp_wr;
  assign pc_en      = redirect || ((state == REQ) && ibus_gnt) || fault_wr;

  always_comb begin
    in_slot = '{inst: NOP_INST, pc: pc, fault: 1'b1};
    if (!fault_wr)
      in_slot = '{inst: ibus_err ? NOP_INST : ibus_rdata, pc: pend_pc, fault: ibus_err};
  end

  // ibus_addr is captured at issue so DREQ keeps the old address after PC is redirected.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ibus_req  <= 1'b0;
      ibus_addr <= 32'h0;
      pend_pc   <= 32'h0;
    end else begin
      case (state)
        IDLE: if (!redirect && skid_empty && !misaligned) begin
          state     <= REQ;
          ibus_req  <= 1'b1;
          ibus_addr <= pc;
        end
        REQ: if (redirect) begin
          state    <= ibus_gnt ? DWAIT : DREQ;
          ibus_req <= !ibus_gnt;
        end else if (ibus_gnt) begin
          state    <= WAIT;
          ibus_req <= 1'b0;
          pend_pc  <= ibus_addr;
        end
        WAIT: if (redirect) begin
          state <= ibus_rvalid ? IDLE : DWAIT;
        end else if (ibus_rvalid) begin
          state <= IDLE;
        end
        DREQ: if (ibus_gnt) begin
          state    <= DWAIT;
          ibus_req <= 1'b0;
        end
        DWAIT: if (ibus_rvalid) state <= IDLE;
        default: begin
          state    <= IDLE;
          ibus_req <= 1'b0;
        end
      endcase
    end
  end

  if_skid_buf #(.NOP_INST(NOP_INST)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_slot    (in_slot),
    .consume    (!id_stall),
    .flush      (redirect),
    .out_valid  (inst_valid),
    .out_slot   (out_slot),
    .skid_empty (skid_empty)
  );

  assign inst       = out_slot.inst;
  assign inst_pc    = out_slot.pc;
  assign inst_fault = out_slot.fault;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: bench plays both the PC register and the
// instruction bus, checking hand-computed values after each edge.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_en;
  logic        redirect;
  logic        id_stall;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_gnt;
  logic        ibus_rvalid;
  logic [31:0] ibus_rdata;
  logic        ibus_err;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_fault;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_fetch_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .pc_en       (pc_en),
    .redirect    (redirect),
    .id_stall    (id_stall),
    .ibus_req    (ibus_req),
    .ibus_addr   (ibus_addr),
    .ibus_gnt    (ibus_gnt),
    .ibus_rvalid (ibus_rvalid),
    .ibus_rdata  (ibus_rdata),
    .ibus_err    (ibus_err),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_fault  (inst_fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; pc = 32'hBFC0_0000; redirect = 1'b0; id_stall = 1'b0;
    ibus_gnt = 1'b0; ibus_rvalid = 1'b0; ibus_rdata = 32'h0; ibus_err = 1'b0;
    tick(); tick();
    chk("rst_req", {31'b0, ibus_req}, 32'd0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_fault", {31'b0, inst_fault}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    rst_n = 1'b1;

    // 1: basic fetch at reset vector
    tick();
    chk("t1_req", {31'b0, ibus_req}, 32'd1);
    chk("t1_addr", ibus_addr, 32'hBFC0_0000);
    chk("t1_pc_en_idle", {31'b0, pc_en}, 32'd0);
    ibus_gnt = 1'b1; settle();
    chk("t1_pc_en_gnt", {31'b0, pc_en}, 32'd1);
    tick();
    pc = 32'hBFC0_0004; ibus_gnt = 1'b0; ibus_rvalid = 1'b1; ibus_rdata = 32'h2402_0001; settle();
    chk("t1_req_off", {31'b0, ibus_req}, 32'd0);
    chk("t1_pc_en_wait", {31'b0, pc_en}, 32'd0);
    chk("t1_valid_early", {31'b0, inst_valid}, 32'd0);
    tick();
    ibus_rvalid = 1'b0;
    chk("t1_valid", {31'b0, inst_valid}, 32'd1);
    chk("t1_inst", inst, 32'h2402_0001);
    chk("t1_inst_pc", inst_pc, 32'hBFC0_0000);
    chk("t1_fault", {31'b0, inst_fault}, 32'd0);

    // 2: redirect while waiting for data
    tick();
    chk("t2_consumed", {31'b0, inst_valid}, 32'd0);
    chk("t2_addr", ibus_addr, 32'hBFC0_0004);
    ibus_gnt = 1'b1;
    tick();
    pc = 32'hBFC0_0008; ibus_gnt = 1'b0; redirect = 1'b1; settle();
    chk("t2_pc_en_redir", {31'b0, pc_en}, 32'd1);
    tick();
    pc = 32'h8000_0180; redirect = 1'b0; settle();
    chk("t2_req_off", {31'b0, ibus_req}, 32'd0);
    tick();
    ibus_rvalid = 1'b1; ibus_rdata = 32'hDEAD_BEEF; settle();
    chk("t2_pc_en_stale", {31'b0, pc_en}, 32'd0);
    tick();
    ibus_rvalid = 1'b0;
    chk("t2_dropped", {31'b0, inst_valid}, 32'd0);
    tick();
    chk("t2_new_req", {31'b0, ibus_req}, 32'd1);
    chk("t2_new_addr", ibus_addr, 32'h8000_0180);
    chk("t2_still_empty", {31'b0, inst_valid}, 32'd0);

    // 3: redirect while requesting, grant arrives later
    redirect = 1'b1; settle();
    chk("t3_pc_en_redir", {31'b0, pc_en}, 32'd1);
    tick();
    redirect = 1'b0; pc = 32'h8000_0200;
    chk("t3_req_hold", {31'b0, ibus_req}, 32'd1);
    chk("t3_addr_hold", ibus_addr, 32'h8000_0180);
    tick();
    chk("t3_req_hold2", {31'b0, ibus_req}, 32'd1);
    chk("t3_addr_hold2", ibus_addr, 32'h8000_0180);
    ibus_gnt = 1'b1; settle();
    chk("t3_no_pc_en", {31'b0, pc_en}, 32'd0);
    tick();
    ibus_gnt = 1'b0;
    chk("t3_req_off", {31'b0, ibus_req}, 32'd0);
    ibus_rvalid = 1'b1; ibus_rdata = 32'h1111_1111;
    tick();
    ibus_rvalid = 1'b0;
    chk("t3_dropped", {31'b0, inst_valid}, 32'd0);

    // 4: ID stalls across two fetches
    id_stall = 1'b1;
    tick();
    chk("t4_addr0", ibus_addr, 32'h8000_0200);
    ibus_gnt = 1'b1;
    tick();
    pc = 32'h8000_0204; ibus_gnt = 1'b0; ibus_rvalid = 1'b1; ibus_rdata = 32'hA000_0001;
    tick();
    ibus_rvalid = 1'b0;
    chk("t4_valid0", {31'b0, inst_valid}, 32'd1);
    chk("t4_inst0", inst, 32'hA000_0001);
    tick();
    chk("t4_req1", {31'b0, ibus_req}, 32'd1);
    chk("t4_addr1", ibus_addr, 32'h8000_0204);
    ibus_gnt = 1'b1;
    tick();
    pc = 32'h8000_0208; ibus_gnt = 1'b0; ibus_rvalid = 1'b1; ibus_rdata = 32'hA000_0002;
    tick();
    ibus_rvalid = 1'b0;
    chk("t4_hold_inst0", inst, 32'hA000_0001);
    tick();
    chk("t4_no_third_req", {31'b0, ibus_req}, 32'd0);
    chk("t4_still_inst0", inst, 32'hA000_0001);
    chk("t4_still_pc0", inst_pc, 32'h8000_0200);
    id_stall = 1'b0;
    tick();
    chk("t4_valid1", {31'b0, inst_valid}, 32'd1);
    chk("t4_inst1", inst, 32'hA000_0002);
    chk("t4_pc1", inst_pc, 32'h8000_0204);

    // 5: misaligned PC, then bus error
    pc = 32'hBFC0_0002; settle();
    chk("t5_pc_en_fault", {31'b0, pc_en}, 32'd1);
    tick();
    chk("t5_no_req", {31'b0, ibus_req}, 32'd0);
    chk("t5_valid", {31'b0, inst_valid}, 32'd1);
    chk("t5_fault", {31'b0, inst_fault}, 32'd1);
    chk("t5_nop", inst, 32'h0);
    chk("t5_fault_pc", inst_pc, 32'hBFC0_0002);
    pc = 32'hBFC0_0010;
    tick();
    chk("t5_consumed", {31'b0, inst_valid}, 32'd0);
    chk("t5_addr", ibus_addr, 32'hBFC0_0010);
    ibus_gnt = 1'b1;
    tick();
    pc = 32'hBFC0_0014; ibus_gnt = 1'b0; ibus_rvalid = 1'b1; ibus_err = 1'b1; ibus_rdata = 32'h1234_5678;
    tick();
    ibus_rvalid = 1'b0; ibus_err = 1'b0;
    chk("t5_err_valid", {31'b0, inst_valid}, 32'd1);
    chk("t5_err_fault", {31'b0, inst_fault}, 32'd1);
    chk("t5_err_nop", inst, 32'h0);
    chk("t5_err_pc", inst_pc, 32'hBFC0_0010);

    // 6: reset mid-transaction
    tick();
    ibus_gnt = 1'b1;
    tick();
    ibus_gnt = 1'b0; pc = 32'hBFC0_0018; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_req", {31'b0, ibus_req}, 32'd0);
    chk("t6_valid", {31'b0, inst_valid}, 32'd0);
    tick();
    chk("t6_idle_reissue", {31'b0, ibus_req}, 32'd1);
    chk("t6_addr", ibus_addr, 32'hBFC0_0018);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
